// File: rtl/time_field_counter.sv
// time_field_counter
//
// One calendar/clock field (seconds, minutes, hours, day, month) with a
// configurable range MIN_VALUE .. TOP. In run mode it advances on `tick` and
// emits a one-cycle `carry` on wrap, so fields chain carry -> tick on a single
// clock. In set mode `up`/`down` step the value with auto-repeat, and the
// two-digit display blinks.
//
// Ports:
//   clock  in   system clock (only clock)
//   reset  in   synchronous, active-high reset
//   tick   in   count enable, one-cycle pulse
//   set    in   1 = adjust mode
//   up     in   increment button (debounced, synchronised, level)
//   down   in   decrement button (debounced, synchronised, level)
//   limit  in   runtime top value, used only when USE_LIMIT = 1
//   count  out  current value
//   carry  out  one-cycle wrap pulse (run mode only)
//   seg    out  active-low segments, [6:0] ones digit, [13:7] tens digit
module time_field_counter #(
  parameter int unsigned MODULO       = 60,
  parameter int unsigned BITS         = 6,
  parameter int unsigned MIN_VALUE    = 0,
  parameter int unsigned USE_LIMIT    = 0,
  parameter int unsigned REPEAT_DELAY = 25_000_000,
  parameter int unsigned REPEAT_RATE  = 5_000_000,
  parameter int unsigned BLINK_HALF   = 12_500_000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            tick,
  input  logic            set,
  input  logic            up,
  input  logic            down,
  input  logic [BITS-1:0] limit,
  output logic [BITS-1:0] count,
  output logic            carry,
  output logic [13:0]     seg
);

  localparam logic [BITS-1:0] MinVal   = BITS'(MIN_VALUE);
  localparam logic [BITS-1:0] FixedTop = BITS'(MIN_VALUE + MODULO - 1);

  localparam int unsigned TimerMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);
  localparam logic [TimerW-1:0] DelayLast = TimerW'(REPEAT_DELAY - 1);
  localparam logic [TimerW-1:0] RateLast  = TimerW'(REPEAT_RATE - 1);

  localparam int unsigned BlinkW = $clog2(BLINK_HALF + 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rpt_state_e;

  // State
  logic [BITS-1:0]   count_q, count_d;
  logic              carry_q, carry_d;
  rpt_state_e        state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              dir_q, dir_d;      // 1 = held button is `up`
  logic              up_q, down_q, set_q;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_on_q, blink_on_d;

  logic [BITS-1:0] top;
  logic            step;
  logic            step_up;
  logic            up_only, down_only, held_same;

  assign top       = (USE_LIMIT != 0) ? limit : FixedTop;
  assign up_only   = up & ~down;
  assign down_only = down & ~up;
  // The button that started the current hold is still the only one pressed.
  assign held_same = dir_q ? up_only : down_only;

  // Repeat FSM: issues single-cycle steps for the held button.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dir_d   = dir_q;
    step    = 1'b0;
    step_up = dir_q;
    if (!set || (up && down)) begin
      state_d = StIdle;
      timer_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          timer_d = '0;
          if (up_only && !up_q) begin
            step    = 1'b1;
            step_up = 1'b1;
            dir_d   = 1'b1;
            state_d = StDelay;
          end else if (down_only && !down_q) begin
            step    = 1'b1;
            step_up = 1'b0;
            dir_d   = 1'b0;
            state_d = StDelay;
          end
        end
        StDelay: begin
          if (!held_same) begin
            state_d = StIdle;
            timer_d = '0;
          end else if (timer_q == DelayLast) begin
            step    = 1'b1;
            state_d = StRepeat;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TimerW'(1);
          end
        end
        StRepeat: begin
          if (!held_same) begin
            state_d = StIdle;
            timer_d = '0;
          end else if (timer_q == RateLast) begin
            step    = 1'b1;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TimerW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          timer_d = '0;
        end
      endcase
    end
  end

  // Count update: clamp beats any tick or step in the same cycle.
  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    if (count_q > top) begin
      count_d = top;
    end else if (!set) begin
      if (tick) begin
        if (count_q == top) begin
          count_d = MinVal;
          carry_d = 1'b1;
        end else begin
          count_d = count_q + BITS'(1);
        end
      end
    end else if (step) begin
      if (step_up) begin
        count_d = (count_q == top) ? MinVal : count_q + BITS'(1);
      end else begin
        count_d = (count_q == MinVal) ? top : count_q - BITS'(1);
      end
    end
  end

  // Blink timer: restarts in the "on" phase on entry to set mode or any step.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (!set || !set_q || step) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (blink_cnt_q == BlinkLast) begin
      blink_cnt_d = '0;
      blink_on_d  = ~blink_on_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BlinkW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q     <= MinVal;
      carry_q     <= 1'b0;
      state_q     <= StIdle;
      timer_q     <= '0;
      dir_q       <= 1'b0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      set_q       <= 1'b0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      count_q     <= count_d;
      carry_q     <= carry_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      dir_q       <= dir_d;
      up_q        <= up;
      down_q      <= down;
      set_q       <= set;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  // Display: gfedcba, active-low.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  logic [6:0] value;
  logic [3:0] tens, ones;
  logic       blank;

  assign value = 7'(count_q);
  assign tens  = 4'(value / 7'd10);
  assign ones  = 4'(value % 7'd10);
  assign blank = set & ~blink_on_q;

  assign count = count_q;
  assign carry = carry_q;
  assign seg   = blank ? 14'h3fff : {seg7(tens), seg7(ones)};

endmodule
